// File: rtl/svc_soc_uart_rx_reg_if.sv
// MMIO read/write bus between the SoC core (master) and the UART RX register bank (slave).
interface svc_soc_uart_rx_reg_if;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;

  modport master (output wen, waddr, wdata, ren, raddr, input rdata);
  modport slave  (input wen, waddr, wdata, ren, raddr, output rdata);
endinterface

// File: rtl/svc_soc_uart_rx_reg.sv
// UART 8N1 receiver with RX FIFO and DATA/STATUS/CTRL MMIO registers.
// Optional stop-bit framing error detection: define SVC_SOC_UART_RX_FRAME_ERR_EN.
module svc_soc_uart_rx_reg #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  svc_soc_uart_rx_reg_if.slave        io,
  input  logic                        uart_rx,
  output logic                        rx_irq
);
  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic              rx_p0, rx_p1;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        idx, idx_n;
  logic [7:0]        shreg, shreg_n;
  logic              push_req, stop_low;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, wptr_n, rptr, rptr_n;
  logic [LW-1:0]     level, level_n;
  logic              overrun, overrun_n, frame_err, frame_err_n;
  logic              empty, full, pop, push_ok, ctrl_wr, flush;
  logic [7:0]        rd_addr, wr_addr, level_sat;
  logic [8:0]        level_ext;

  // Stage 0/1: two-flop synchronizer, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    push_req = 1'b0;
    stop_low = 1'b0;
    case (state)
      IDLE: if (!rx_p1) begin
        state_n = START;
        cnt_n   = CW'(CPB / 2 - 1);
      end
      START: if (cnt == '0) begin
        if (!rx_p1) begin
          state_n = DATA;
          cnt_n   = CW'(CPB - 1);
          idx_n   = 3'd0;
        end else begin
          state_n = IDLE;
        end
      end else begin
        cnt_n = cnt - 1'b1;
      end
      DATA: if (cnt == '0) begin
        shreg_n = {rx_p1, shreg[7:1]};
        cnt_n   = CW'(CPB - 1);
        idx_n   = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end else begin
        cnt_n = cnt - 1'b1;
      end
      STOP: if (cnt == '0) begin
        push_req = 1'b1;
        stop_low = !rx_p1;
        state_n  = IDLE;
      end else begin
        cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk) shreg <= shreg_n;

  assign rd_addr = io.raddr[7:0];
  assign wr_addr = io.waddr[7:0];
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = io.ren && (rd_addr == 8'h00) && !empty;
  assign ctrl_wr = io.wen && (wr_addr == 8'h08);
  assign flush   = ctrl_wr && io.wdata[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    wptr_n      = wptr;
    rptr_n      = rptr;
    level_n     = level;
    overrun_n   = overrun;
    frame_err_n = 1'b0;
    if (push_ok) wptr_n = wptr + 1'b1;
    if (pop)     rptr_n = rptr + 1'b1;
    if (push_ok && !pop) level_n = level + 1'b1;
    if (pop && !push_ok) level_n = level - 1'b1;
    if (flush) begin
      wptr_n  = '0;
      rptr_n  = '0;
      level_n = '0;
    end
    if (ctrl_wr && io.wdata[1]) overrun_n = 1'b0;
    if (push_req && full && !pop) overrun_n = 1'b1;
`ifdef SVC_SOC_UART_RX_FRAME_ERR_EN
    frame_err_n = frame_err;
    if (ctrl_wr && io.wdata[2]) frame_err_n = 1'b0;
    if (push_req && stop_low)   frame_err_n = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      level     <= level_n;
      overrun   <= overrun_n;
      frame_err <= frame_err_n;
      rx_irq    <= (level_n != '0) | frame_err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr] <= shreg;
  end

  assign level_ext = 9'(level);
  assign level_sat = level_ext[8] ? 8'hFF : level_ext[7:0];

  // Stage 2: registered read data, held while io.ren is low
  always_ff @(posedge clk) begin
    if (rst) begin
      io.rdata <= 32'h0;
    end else if (io.ren) begin
      case (rd_addr)
        8'h00:   io.rdata <= empty ? 32'h0 : {23'h0, 1'b1, mem[rptr]};
        8'h04:   io.rdata <= {16'h0, level_sat, 5'h0, frame_err, overrun, ~empty};
        default: io.rdata <= 32'h0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{io.waddr[31:8], io.raddr[31:8], io.wdata[31:3]};
`ifndef SVC_SOC_UART_RX_FRAME_ERR_EN
  logic unused_cfg;
  assign unused_cfg = ^{stop_low, io.wdata[2]};
`endif
endmodule

// File: tb/tb_svc_soc_uart_rx_reg.sv
// Self-checking bench for svc_soc_uart_rx_reg: vector table, corner sequences, randomized ops vs. a queue model.
module tb_svc_soc_uart_rx_reg;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic rx_irq;
  int   checks = 0;
  int   errors = 0;

  svc_soc_uart_rx_reg_if bus ();

  svc_soc_uart_rx_reg #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io     (bus),
    .uart_rx(uart_rx),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO contents as a queue plus the two sticky flags
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;

`ifdef SVC_SOC_UART_RX_FRAME_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  function automatic void m_push(input logic [7:0] b, input logic stop_bit);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovr = 1'b1;
    if (FE_EN && !stop_bit) m_fe = 1'b1;
  endfunction

  function automatic logic [31:0] m_data();
    logic [7:0] b;
    if (mq.size() == 0) return 32'h0;
    b = mq.pop_front();
    return {23'h0, 1'b1, b};
  endfunction

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(mq.size()), 5'h0, m_fe, m_ovr, mq.size() != 0};
  endfunction

  function automatic void m_ctrl(input logic [2:0] w);
    if (w[0]) mq.delete();
    if (w[1]) m_ovr = 1'b0;
    if (w[2]) m_fe = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(6);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.ren   = 1'b1;
    bus.raddr = {24'h0, a};
    @(posedge clk);
    @(negedge clk);
    bus.ren = 1'b0;
    d = bus.rdata;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.wen   = 1'b1;
    bus.waddr = {24'h0, a};
    bus.wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [4];
  logic [31:0] d;
  logic [7:0]  rb;
  logic        sb;
  logic [2:0]  cw;

  initial begin
    tbl[0] = '{8'hA5, 32'h0000_01A5};
    tbl[1] = '{8'h00, 32'h0000_0100};
    tbl[2] = '{8'hFF, 32'h0000_01FF};
    tbl[3] = '{8'h81, 32'h0000_0181};

    rst = 1'b1; uart_rx = 1'b1;
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.ren = 1'b0; bus.raddr = '0;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_irq", {31'h0, rx_irq}, 32'h0);
    rd(8'h04, d); chk("reset_status", d, 32'h0);

    foreach (tbl[i]) begin
      send_byte(tbl[i].b, 1'b1);
      rd(8'h00, d); chk("tbl_data", d, tbl[i].exp);
      rd(8'h04, d); chk("tbl_status", d, 32'h0);
    end

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    rd(8'h04, d); chk("three_status", d, 32'h0000_0301);
    chk("three_irq", {31'h0, rx_irq}, 32'h1);
    bus.ren = 1'b1; bus.raddr = 32'h0;
    @(posedge clk); @(negedge clk); chk("b2b_0", bus.rdata, 32'h111);
    @(posedge clk); @(negedge clk); chk("b2b_1", bus.rdata, 32'h122);
    @(posedge clk); @(negedge clk); chk("b2b_2", bus.rdata, 32'h133);
    bus.ren = 1'b0;
    tick(2);
    chk("three_irq_drop", {31'h0, rx_irq}, 32'h0);

    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1);
    rd(8'h04, d); chk("ovr_status", d, 32'h0000_0403);
    wr(8'h08, 32'h2);
    rd(8'h04, d); chk("ovr_clear", d, 32'h0000_0401);
    for (int i = 0; i < 4; i++) begin
      rd(8'h00, d); chk("ovr_data", d, 32'h110 + 32'(i));
    end
    tick(3);
    chk("rdata_hold", bus.rdata, 32'h113);
    rd(8'h00, d); chk("empty_data", d, 32'h0);
    rd(8'h0C, d); chk("other_offset", d, 32'h0);

    uart_rx = 1'b0; tick(3); uart_rx = 1'b1; tick(20);
    rd(8'h04, d); chk("glitch_status", d, 32'h0);

    send_byte(8'h77, 1'b1);
    rd(8'h04, d); chk("pre_rst_status", d, 32'h0000_0101);
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = rb[0] ^ 1'b0 ? 1'b0 : 1'b0;
      uart_rx = (8'h5A >> i) & 1'b1;
      tick(CPB);
    end
    uart_rx = 1'b1; tick(5);
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    chk("rst_mid_irq", {31'h0, rx_irq}, 32'h0);
    tick(20);
    rd(8'h04, d); chk("rst_mid_status", d, 32'h0);
    send_byte(8'h5A, 1'b1);
    rd(8'h00, d); chk("post_rst_data", d, 32'h15A);

    send_byte(8'h3C, 1'b0);
    rd(8'h00, d); chk("fe_data", d, 32'h13C);
    rd(8'h04, d); chk("fe_status", d, FE_EN ? 32'h4 : 32'h0);
    chk("fe_irq", {31'h0, rx_irq}, {31'h0, FE_EN});
    wr(8'h08, 32'h4);
    rd(8'h04, d); chk("fe_clear", d, 32'h0);

    wr(8'h08, 32'h7);
    mq.delete(); m_ovr = 1'b0; m_fe = 1'b0;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          rb = 8'($urandom);
          sb = ($urandom_range(0, 7) != 0);
          send_byte(rb, sb);
          m_push(rb, sb);
        end
        2: begin
          rd(8'h00, d); chk("rnd_data", d, m_data());
        end
        3: begin
          rd(8'h04, d); chk("rnd_status", d, m_status());
        end
        default: begin
          cw = 3'($urandom);
          if (cw[0] && $urandom_range(0, 1) == 0) cw[0] = 1'b0;
          wr(8'h08, {29'h0, cw});
          m_ctrl(cw);
        end
      endcase
      tick(2);
      chk("rnd_irq", {31'h0, rx_irq}, {31'h0, (mq.size() != 0) | m_fe});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
